// File: rtl/mul_seq_32_pkg.sv
// Shared constants for the iterative shift-add multiplier: default widths
// and the FSM state encoding.
package mul_seq_32_pkg;

    localparam int unsigned MUL_WIDTH = 32;
    localparam int unsigned MUL_CNT_W = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : mul_seq_32_pkg

// File: rtl/mul_seq_32.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH multiplier that borrows the datapath's
// external adder, retiring one partial product per clock.
module mul_seq_32
    import mul_seq_32_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = MUL_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_sub,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 out_zero
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [PW-1:0]    out_prod_q, out_prod_d;
    logic             out_zero_q, out_zero_d;
    logic [PW-1:0]    shift_sum;

    // Adder operands: accumulated high half plus the multiplicand when the
    // current multiplier bit is set; idle operands are zero.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (state_q == ST_RUN) begin
            add_a = p_hi_q;
            add_b = p_lo_q[0] ? mcand_q : '0;
        end
    end

    assign add_sub = 1'b0;

    // Carry-out lands in the product msb; the retired multiplier bit drops off.
    assign shift_sum = {add_cout, add_sum, p_lo_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            p_hi_q      <= '0;
            p_lo_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_prod_q  <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            p_hi_q      <= p_hi_d;
            p_lo_q      <= p_lo_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_prod_q  <= out_prod_d;
            out_zero_q  <= out_zero_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        p_hi_d     = p_hi_q;
        p_lo_d     = p_lo_q;
        cnt_d      = cnt_q;
        out_prod_d = out_prod_q;
        out_zero_d = out_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    mcand_d = in_a;
                    p_lo_d  = in_b;
                    p_hi_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                {p_hi_d, p_lo_d} = shift_sum;
                cnt_d            = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d    = ST_DONE;
                    out_prod_d = shift_sum;
                    out_zero_d = (shift_sum == '0);
                end
            end
            ST_DONE: begin
                if (out_valid_q && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_prod  = out_prod_q;
    assign out_zero  = out_zero_q;

endmodule : mul_seq_32

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32 with the shared 32-bit adder modelled
// alongside; products are checked against plain 64-bit multiplication.
module tb_mul_seq_32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_sub;
    logic [31:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prod;
    logic        out_zero;

    int tests_run;
    int tests_failed;
    int cyc;
    int sub_bad;

    mul_seq_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sub   (add_sub),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_zero  (out_zero)
    );

    // Shared datapath adder.
    assign {add_cout, add_sum} = 33'(add_a) + 33'(add_b) + 33'(add_sub);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (add_sub !== 1'b0) sub_bad <= sub_bad + 1;

    // Present one operand pair, wait for acceptance, then wait for the result.
    task automatic do_job(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int acc_cyc);
        int w;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_prod !== 64'd0 || out_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: valid=%b ready=%b prod=%h zero=%b, want 0 1 0 0",
                     out_valid, in_ready, out_prod, out_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, acc;
        out_ready = 1'b1;
        sub_bad = 0;
        do_job(32'd3, 32'd5, lat, acc);
        tests_run++;
        if (lat !== 32) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d edges after accept, want 32", lat);
        end
        tests_run++;
        if (out_prod !== 64'h0000_0000_0000_000F || out_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_prod: got %h zero=%b, want 000000000000000f zero=0", out_prod, out_zero);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_return: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        tests_run++;
        if (sub_bad !== 0) begin
            tests_failed++;
            $display("FAIL add_sub: %0d cycles with add_sub high, want 0", sub_bad);
        end
    endtask

    task automatic test_max();
        int lat, acc;
        do_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, acc);
        tests_run++;
        if (out_prod !== 64'hFFFF_FFFE_0000_0001 || out_zero !== 1'b0 || lat !== 32) begin
            tests_failed++;
            $display("FAIL max_prod: got %h zero=%b lat=%0d, want fffffffe00000001 0 32",
                     out_prod, out_zero, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int lat, acc;
        do_job(32'd0, 32'h1234_5678, lat, acc);
        tests_run++;
        if (out_prod !== 64'd0 || out_zero !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_prod: got %h zero=%b, want 0 zero=1", out_prod, out_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat, acc;
        int bad;
        out_ready = 1'b0;
        do_job(32'h8000_0000, 32'd2, lat, acc);
        tests_run++;
        if (out_prod !== 64'h0000_0001_0000_0000 || lat !== 32) begin
            tests_failed++;
            $display("FAIL bp_prod: got %h lat=%0d, want 0000000100000000 32", out_prod, lat);
        end
        in_a = 32'd9;
        in_b = 32'd9;
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_prod !== 64'h0000_0001_0000_0000 || in_ready !== 1'b0)
                bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d of 10 stalled cycles unstable, want 0", bad);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_ignored: ready=%b after release, want 1 (no job started)", in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat, acc, w;
        // Abandon during RUN.
        in_a = 32'hDEAD_BEEF;
        in_b = 32'h0001_2345;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_run: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        // Abandon during DONE.
        out_ready = 1'b0;
        do_job(32'd11, 32'd13, lat, acc);
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_prod !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_done: valid=%b ready=%b prod=%h, want 0 1 0", out_valid, in_ready, out_prod);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        do_job(32'd7, 32'd6, lat, acc);
        tests_run++;
        if (out_prod !== 64'd42 || lat !== 32) begin
            tests_failed++;
            $display("FAIL reset_recover: got %h lat=%0d, want 42 32", out_prod, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, acc, prev_acc;
        logic [31:0] a, b;
        logic [63:0] exp_p;
        out_ready = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 100; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 10 == 3) a = 32'hFFFF_FFFF;
            if (i % 10 == 7) b = 32'd0;
            exp_p = 64'(a) * 64'(b);
            do_job(a, b, lat, acc);
            tests_run++;
            if (out_prod !== exp_p || out_zero !== (exp_p == 64'd0) || lat !== 32) begin
                tests_failed++;
                $display("FAIL b2b_prod[%0d]: %h*%h got %h zero=%b lat=%0d, want %h lat=32",
                         i, a, b, out_prod, out_zero, lat, exp_p);
            end
            if (i > 0) begin
                tests_run++;
                if (acc - prev_acc !== 34) begin
                    tests_failed++;
                    $display("FAIL b2b_interval[%0d]: got %0d cycles, want 34", i, acc - prev_acc);
                end
            end
            prev_acc = acc;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        cyc = 0;
        sub_bad = 0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_mul_seq_32
